// File: rtl/eth_frame_detector_pkg.sv
// Shared definitions for the frame-detector log path: header layout and reader states.
package eth_frame_detector_pkg;

  localparam int C_LOG_HDR_BITS = 128;

  localparam int HDR_TYPE_LSB  = 0;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_TS_LSB    = 32;
  localparam int HDR_SIZE_LSB  = 96;
  localparam int HDR_MATCH_LSB = 112;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_DISCARD
  } log_rd_state_t;

endpackage

// File: rtl/eth_frame_loop_log_reader.sv
// Log-domain reader: pops one ctl record, emits a 128-bit header then the frame words
// as one AXI-Stream message, or silently drains the frame words when disabled.
module eth_frame_loop_log_reader
  import eth_frame_detector_pkg::*;
#(
  parameter int          C_NUM_SCRIPTS      = 4,
  parameter int          C_NUM_SCRIPTS_CEIL = 8,
  parameter int          C_AXIS_LOG_WIDTH   = 64,
  parameter logic [15:0] C_MSG_TYPE         = 16'h0003
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             srst,
  input  logic                             enable,
  input  logic [C_NUM_SCRIPTS_CEIL+79:0]   s_axis_ctl_tdata,
  input  logic                             s_axis_ctl_tvalid,
  output logic                             s_axis_ctl_tready,
  input  logic [C_AXIS_LOG_WIDTH-1:0]      s_axis_frame_tdata,
  input  logic                             s_axis_frame_tvalid,
  output logic                             s_axis_frame_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0]      m_axis_log_tdata,
  output logic                             m_axis_log_tvalid,
  input  logic                             m_axis_log_tready,
  output logic                             m_axis_log_tlast,
  output logic [63:0]                      drop_count,
  output logic                             busy
);

  localparam int W     = C_AXIS_LOG_WIDTH;
  localparam int BYTES = W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int NSL   = C_LOG_HDR_BITS / W;
  localparam int SLW   = (NSL > 1) ? $clog2(NSL) : 1;

  generate
    if (C_NUM_SCRIPTS > C_NUM_SCRIPTS_CEIL || C_NUM_SCRIPTS_CEIL > 16) begin : g_bad_cfg
      $error("eth_frame_loop_log_reader: MATCHED field too narrow or wider than 16 bits");
    end
  endgenerate

  log_rd_state_t r_state;
  logic [C_LOG_HDR_BITS-1:0] r_hdr;
  logic [15:0]               r_nw;
  logic [SLW-1:0]            r_slice;
  logic [W-1:0]              r_tdata;
  logic                      r_tvalid;
  logic                      r_tlast;
  logic [63:0]               r_drop;
  logic                      r_run;

  logic [C_NUM_SCRIPTS_CEIL-1:0] w_match;
  logic [15:0]               w_size;
  logic [63:0]               w_ts;
  logic [16:0]               w_sum;
  logic [15:0]               w_nw;
  logic [15:0]               w_len;
  logic [C_LOG_HDR_BITS-1:0] w_hdr;
  logic                      w_out_free;
  logic                      w_ctl_hs;
  logic                      w_frm_hs;
  logic                      w_last_slice;
  logic                      w_drop_inc;

  assign w_match = s_axis_ctl_tdata[80 +: C_NUM_SCRIPTS_CEIL];
  assign w_size  = s_axis_ctl_tdata[64 +: 16];
  assign w_ts    = s_axis_ctl_tdata[63:0];

  // 17-bit sum so SIZE=16'hFFFF rounds up instead of wrapping to zero words
  assign w_sum = {1'b0, w_size} + 17'(BYTES - 1);
  assign w_nw  = 16'(w_sum >> BSH);
  assign w_len = 16'(w_nw << BSH);

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_TYPE_LSB  +: 16] = C_MSG_TYPE;
    w_hdr[HDR_LEN_LSB   +: 16] = w_len;
    w_hdr[HDR_TS_LSB    +: 64] = w_ts;
    w_hdr[HDR_SIZE_LSB  +: 16] = w_size;
    w_hdr[HDR_MATCH_LSB +: 16] = 16'(w_match);
  end

  assign w_out_free   = ~r_tvalid | m_axis_log_tready;
  assign w_last_slice = (r_slice == SLW'(NSL - 1));

  assign s_axis_ctl_tready   = r_run & (r_state == ST_IDLE);
  assign s_axis_frame_tready = ((r_state == ST_DATA) & w_out_free) |
                               ((r_state == ST_DISCARD) & (r_nw != 16'd0));

  assign w_ctl_hs   = s_axis_ctl_tvalid & s_axis_ctl_tready;
  assign w_frm_hs   = s_axis_frame_tvalid & s_axis_frame_tready;
  assign w_drop_inc = (r_state == ST_DISCARD) &
                      ((r_nw == 16'd0) | (w_frm_hs & (r_nw == 16'd1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_hdr    <= '0;
      r_nw     <= '0;
      r_slice  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_drop   <= '0;
      r_run    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      // an accepted word empties the out reg unless a load below refills it
      if (m_axis_log_tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (srst)            r_drop <= '0;
      else if (w_drop_inc) r_drop <= r_drop + 64'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_ctl_hs) begin
            r_hdr   <= w_hdr;
            r_nw    <= w_nw;
            r_slice <= '0;
            r_state <= enable ? ST_HEADER : ST_DISCARD;
          end
        end
        ST_HEADER: begin
          if (w_out_free) begin
            r_tdata  <= r_hdr[r_slice*W +: W];
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            if (w_last_slice) begin
              r_slice <= '0;
              if (r_nw == 16'd0) begin
                r_tlast <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_slice <= r_slice + SLW'(1);
            end
          end
        end
        ST_DATA: begin
          if (w_frm_hs) begin
            r_tdata  <= s_axis_frame_tdata;
            r_tvalid <= 1'b1;
            r_tlast  <= (r_nw == 16'd1);
            r_nw     <= r_nw - 16'd1;
            if (r_nw == 16'd1) r_state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (r_nw == 16'd0) begin
            r_state <= ST_IDLE;
          end else if (w_frm_hs) begin
            r_nw <= r_nw - 16'd1;
            if (r_nw == 16'd1) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_log_tdata  = r_tdata;
  assign m_axis_log_tvalid = r_tvalid;
  assign m_axis_log_tlast  = r_tlast;
  assign drop_count        = r_drop;
  assign busy              = (r_state != ST_IDLE);

endmodule
